ram_bist: RTL and testbench
===========================

Name: ram_bist

Overview:
- March-style built-in self-test engine that sits directly upstream of the single-port RAM and owns its port while running.
- It drives the RAM's clk-domain write/read/enable/address/data inputs and consumes the RAM's data_out and en_out.
- It reports pass/fail with the first failing address, phase and data.
- It is used at power-up and on demand from a control register.

Parameters:
ADDR_WIDTH, 4, RAM address width; the test covers addresses 0..2^ADDR_WIDTH-1
DATA_WIDTH, 8, RAM data width
PATTERN, 8'h55, background pattern P; its complement ~P is also used
TIMEOUT, 15, maximum cycles to wait for ram_en_out after a read request

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-high
start  input  1  one-cycle pulse that begins a test; ignored while busy
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at test end
pass  output  1  result of the last test, held until next start or reset
fail_addr  output  ADDR_WIDTH  address of the first failure
fail_phase  output  2  march element (0-3) of the first failure
fail_data  output  DATA_WIDTH  data read at the failure (0 on timeout)
fail_timeout  output  1  failure was caused by timeout, not mismatch
ram_en  output  1  RAM enable
ram_wr_rd  output  1  1 = write, 0 = read
ram_addr  output  ADDR_WIDTH  RAM address
ram_data_in  output  DATA_WIDTH  RAM write data
ram_data_out  input  DATA_WIDTH  RAM read data, valid while ram_en_out is high
ram_en_out  input  1  RAM read-data-valid strobe

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - busy, done, pass, fail_timeout, ram_en, ram_wr_rd = 0.
  - ram_addr, ram_data_in, fail_addr, fail_phase, fail_data = 0.
- March sequence (N = 2^ADDR_WIDTH):
  - M0: ascending, write P.
  - M1: ascending, read expect P, then write ~P.
  - M2: descending, read expect ~P, then write P.
  - M3: descending, read expect P.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, NEXT, FINISH.
- IDLE:
  - On start: busy = 1, pass = 0, fail_* cleared, phase = 0, addr = 0, go to WR.
- WR:
  - ram_en = 1, ram_wr_rd = 1, addr and data presented for exactly one cycle; the RAM captures on that edge.
  - Then go to NEXT.
  - In M1/M2 the write follows the read at the same address.
- RD_REQ:
  - ram_en = 1, ram_wr_rd = 0 for one cycle, then go to RD_WAIT.
  - The timeout counter is cleared.
- RD_WAIT:
  - ram_en = 1, ram_wr_rd = 0, address held. The counter increments each cycle.
  - ram_en_out = 1 and data == expected: go to WR (M1/M2) or NEXT (M3).
  - ram_en_out = 1 and data != expected: record fail_addr/fail_phase/fail_data, go to FINISH with pass = 0.
  - Counter reaches TIMEOUT with no ram_en_out: fail_timeout = 1, fail_data = 0, record addr/phase, go to FINISH.
- NEXT:
  - Advance the address (up for M0/M1, down for M2/M3).
  - At the last address (N-1 ascending, 0 descending):
    - Advance phase and load the start address for the new phase: M2 starts at N-1.
    - After M3 completes, go to FINISH with pass = 1.
  - Otherwise go to WR (M0) or RD_REQ.
  - Address arithmetic is ADDR_WIDTH wide. The end test uses an explicit compare, never wrap-around.
- FINISH:
  - done = 1 for one cycle, busy = 0 in the same cycle, go to IDLE.
  - ram_en = 0 in FINISH and IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - start in the first IDLE cycle after FINISH is accepted.
- Spurious input: ram_en_out outside RD_WAIT is ignored.
- Reset mid-test: abort immediately, ram_en drops asynchronously, no done pulse.
- Stop on first failure; only the first failure is reported.

Test Plan:
- Fault-free RAM model, read latency 2 cycles, defaults -> pass = 1, done exactly once, 48 writes and 48 reads observed, fail_timeout = 0.
- Model with bit 0 stuck-at-0 at address 5 -> fail_phase = 1, fail_addr = 5, fail_data = 8'h54, pass = 0, fail_timeout = 0.
- Model with address 9 holding its value (writes ignored) -> fail_phase = 1 mismatch at fail_addr = 9 when the power-up value is not 8'h55; otherwise fail_phase = 2 at addr 9, fail_data = 8'h55.
- ram_en_out tied 0 -> first read at addr 0, phase 1 times out after TIMEOUT cycles in RD_WAIT; fail_timeout = 1, fail_data = 0.
- start pulsed again mid-test and in the FINISH cycle -> ignored; a single done pulse; start one cycle later re-runs and passes.
- rst asserted during M2 -> all outputs 0 within the same cycle, no done; a fresh start afterwards gives pass = 1.

Source files
------------

// File: rtl/ram_bist.sv
// March-style BIST for a single-port RAM: M0 up-write P, M1 up read P / write ~P,
// M2 down read ~P / write P, M3 down read P. Reports the first failure only.
module ram_bist #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_phase,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_timeout,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_en_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [1:0]            fail_phase_q, fail_phase_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic                  fail_timeout_q, fail_timeout_d;

  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ascending;
  logic                  at_last;

  // M2 expects ~P back; M1 is the only element that writes ~P.
  assign exp_data  = (phase_q == 2'd2) ? ~PATTERN : PATTERN;
  assign wr_data   = (phase_q == 2'd1) ? ~PATTERN : PATTERN;
  assign ascending = (phase_q < 2'd2);
  assign at_last   = ascending ? (addr_q == ADDR_LAST) : (addr_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      pass_q         <= 1'b0;
      fail_addr_q    <= '0;
      fail_phase_q   <= '0;
      fail_data_q    <= '0;
      fail_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      pass_q         <= pass_d;
      fail_addr_q    <= fail_addr_d;
      fail_phase_q   <= fail_phase_d;
      fail_data_q    <= fail_data_d;
      fail_timeout_q <= fail_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    pass_d         = pass_q;
    fail_addr_d    = fail_addr_q;
    fail_phase_d   = fail_phase_q;
    fail_data_d    = fail_data_q;
    fail_timeout_d = fail_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_WR;
          pass_d         = 1'b0;
          phase_d        = '0;
          addr_d         = '0;
          fail_addr_d    = '0;
          fail_phase_d   = '0;
          fail_data_d    = '0;
          fail_timeout_d = 1'b0;
        end
      end
      S_WR: state_d = S_NEXT;
      S_RD_REQ: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ram_en_out) begin
          if (ram_data_out == exp_data) begin
            state_d = (phase_q == 2'd3) ? S_NEXT : S_WR;
          end else begin
            fail_addr_d  = addr_q;
            fail_phase_d = phase_q;
            fail_data_d  = ram_data_out;
            pass_d       = 1'b0;
            state_d      = S_FINISH;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fail_timeout_d = 1'b1;
          fail_data_d    = '0;
          fail_addr_d    = addr_q;
          fail_phase_d   = phase_q;
          pass_d         = 1'b0;
          state_d        = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (at_last) begin
          if (phase_q == 2'd3) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            phase_d = phase_q + 2'd1;
            addr_d  = (phase_q == 2'd0) ? '0 : ADDR_LAST;
            state_d = S_RD_REQ;
          end
        end else begin
          addr_d  = ascending ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
          state_d = (phase_q == 2'd0) ? S_WR : S_RD_REQ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
    done         = (state_q == S_FINISH);
    ram_en       = (state_q == S_WR) || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    ram_wr_rd    = (state_q == S_WR);
    ram_addr     = addr_q;
    ram_data_in  = (state_q == S_WR) ? wr_data : '0;
    pass         = pass_q;
    fail_addr    = fail_addr_q;
    fail_phase   = fail_phase_q;
    fail_data    = fail_data_q;
    fail_timeout = fail_timeout_q;
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist against a 2-cycle-latency RAM model with
// selectable stuck-at / write-ignore faults and a tie-off of the valid strobe.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, fail_timeout;
  logic [3:0] fail_addr;
  logic [1:0] fail_phase;
  logic [7:0] fail_data;
  logic       ram_en, ram_wr_rd;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_en_out;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: fault-free, 1: addr 5 bit0 stuck-at-0, 2: addr 9 ignores writes
  int         fault = 0;
  logic       tie0  = 1'b0;
  logic [7:0] pu_val = 8'h00;

  logic [7:0] mem [16];
  logic       p1_v, p2_v;
  logic [7:0] p1_d, p2_d;

  int   n_wr = 0, n_rd = 0, n_rd_cyc = 0, n_done = 0;
  logic rd_prev = 1'b0;

  always #5 clk = ~clk;

  ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PATTERN(8'h55), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_phase(fail_phase), .fail_data(fail_data),
    .fail_timeout(fail_timeout), .ram_en(ram_en), .ram_wr_rd(ram_wr_rd),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_en_out(ram_en_out)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= pu_val;
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      p1_d <= 8'h00;
      p2_d <= 8'h00;
    end else begin
      if (ram_en && ram_wr_rd && !(fault == 2 && ram_addr == 4'd9))
        mem[ram_addr] <= (fault == 1 && ram_addr == 4'd5) ? (ram_data_in & 8'hFE) : ram_data_in;
      p1_v <= ram_en && !ram_wr_rd;
      p1_d <= mem[ram_addr];
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  assign ram_en_out   = p2_v && !tie0;
  assign ram_data_out = p2_d;

  always @(posedge clk) begin
    if (ram_en && ram_wr_rd) n_wr <= n_wr + 1;
    if (ram_en && !ram_wr_rd && !rd_prev) n_rd <= n_rd + 1;
    if (ram_en && !ram_wr_rd) n_rd_cyc <= n_rd_cyc + 1;
    rd_prev <= ram_en && !ram_wr_rd;
    if (done) n_done <= n_done + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at a negedge inside the FINISH cycle.
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check_eq({tag, "_done_seen"}, 0, 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int f, input logic t0, input logic [7:0] pv, input string tag);
    fault  = f;
    tie0   = t0;
    pu_val = pv;
    do_reset();
    pulse_start();
    wait_done(tag);
    settle();
  endtask

  int s_wr, s_rd, s_rc, s_dn;

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_rc = n_rd_cyc; s_dn = n_done;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_wr_rd", ram_wr_rd, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_din", ram_data_in, 0);
    check_eq("rst_fail", {fail_timeout, fail_addr, fail_phase, fail_data}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // fault-free
    fault = 0; tie0 = 0; pu_val = 8'h00;
    do_reset();
    snap();
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    wait_done("good");
    check_eq("good_busy_in_finish", busy, 0);
    settle();
    check_eq("good_pass", pass, 1);
    check_eq("good_timeout", fail_timeout, 0);
    check_eq("good_writes", n_wr - s_wr, 48);
    check_eq("good_reads", n_rd - s_rd, 48);
    check_eq("good_done_cnt", n_done - s_dn, 1);
    check_eq("good_ram_en_idle", ram_en, 0);

    // bit 0 stuck-at-0 at address 5
    run_case(1, 0, 8'h00, "sa0");
    check_eq("sa0_pass", pass, 0);
    check_eq("sa0_phase", fail_phase, 1);
    check_eq("sa0_addr", fail_addr, 5);
    check_eq("sa0_data", fail_data, 8'h54);
    check_eq("sa0_timeout", fail_timeout, 0);

    // address 9 ignores writes, power-up 00 -> caught in M1
    run_case(2, 0, 8'h00, "hold00");
    check_eq("hold00_phase", fail_phase, 1);
    check_eq("hold00_addr", fail_addr, 9);
    check_eq("hold00_data", fail_data, 8'h00);
    check_eq("hold00_pass", pass, 0);

    // address 9 ignores writes, power-up 55 -> caught in M2
    run_case(2, 0, 8'h55, "hold55");
    check_eq("hold55_phase", fail_phase, 2);
    check_eq("hold55_addr", fail_addr, 9);
    check_eq("hold55_data", fail_data, 8'h55);

    // valid strobe tied low -> timeout on first read
    fault = 0; tie0 = 1; pu_val = 8'h00;
    do_reset();
    snap();
    pulse_start();
    wait_done("to");
    settle();
    check_eq("to_timeout", fail_timeout, 1);
    check_eq("to_data", fail_data, 0);
    check_eq("to_addr", fail_addr, 0);
    check_eq("to_phase", fail_phase, 1);
    check_eq("to_pass", pass, 0);
    check_eq("to_read_cycles", n_rd_cyc - s_rc, 16);
    tie0 = 0;

    // start mid-test and in FINISH ignored; start in first IDLE cycle accepted
    do_reset();
    snap();
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    pulse_start();
    wait_done("restart1");
    start = 1'b1;
    settle();
    start = 1'b0;
    check_eq("finish_start_ignored", busy, 0);
    check_eq("restart1_pass", pass, 1);
    check_eq("restart1_writes", n_wr - s_wr, 48);
    check_eq("restart1_done_cnt", n_done - s_dn, 1);
    pulse_start();
    check_eq("idle_start_accepted", busy, 1);
    check_eq("restart_clears_pass", pass, 0);
    wait_done("restart2");
    settle();
    check_eq("restart2_pass", pass, 1);
    check_eq("restart2_done_cnt", n_done - s_dn, 2);

    // reset during M2
    do_reset();
    snap();
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (n_wr - s_wr >= 34) begin
          hit = 1;
          break;
        end
      end
      if (!hit) check_eq("m2_reached", 0, 1);
    end
    check_eq("m2_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_ram_en", ram_en, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_addr", ram_addr, 0);
    check_eq("midrst_outs", {pass, fail_timeout, fail_addr, fail_phase, fail_data, ram_wr_rd, ram_data_in}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_done", n_done - s_dn, 0);
    pulse_start();
    wait_done("post_rst");
    settle();
    check_eq("post_rst_pass", pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
